// File: rtl/peripheral_timer_if.sv
// ----------------------------------------------------------------------------
// peripheral_timer_if
//   J1 I/O bus slave handshake shared by the SoC peripherals.
//   Signals:
//     d_in  [15:0]  write data from the J1 core
//     cs            chip select from the SoC address decoder
//     addr  [3:0]   register select
//     rd, wr        read / write strobes
//     d_out [15:0]  read data returned to the SoC read mux
//   Modports: master (bus driver: core or testbench), slave (peripheral).
// ----------------------------------------------------------------------------
interface peripheral_timer_if;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;

    modport master (
        output d_in, cs, addr, rd, wr,
        input  d_out
    );

    modport slave (
        input  d_in, cs, addr, rd, wr,
        output d_out
    );
endinterface

// File: rtl/peripheral_timer.sv
// ----------------------------------------------------------------------------
// peripheral_timer
//   Programmable prescaled timer on the J1 I/O bus. Counts prescaled ticks up
//   to a compare value, then sets a sticky DONE flag and an optional level
//   interrupt. One-shot and periodic (auto-restart) modes.
//
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   peripheral_timer_if.slave (d_in, cs, addr, rd, wr, d_out)
//     irq   registered level interrupt = DONE & IRQ_EN, one clock late
//
//   Register map (16-bit, addr[3:0]):
//     0x0 CTRL      [0]EN [1]PERIODIC [2]IRQ_EN
//     0x2 PRESCALE  one tick every PRESCALE+1 clocks
//     0x4 COMPARE   terminal count
//     0x6 COUNT     current count; write also clears the prescaler
//     0x8 STATUS    R: [0]DONE [1]RUNNING [15:8]match count   W: bit0=1 clears DONE
//
//   Build option: define TIMER_MATCH_COUNT_EN to add an 8-bit saturating
//   count of matches since DONE was last cleared, read in STATUS[15:8].
//   Without it STATUS[15:8] reads 0 and no counter is built.
// ----------------------------------------------------------------------------
module peripheral_timer #(
    parameter logic [15:0] PRESCALE_RST = 16'h0000,
    parameter logic [15:0] COMPARE_RST  = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    rst,
    peripheral_timer_if.slave       bus,
    output logic                    irq
);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t      state_q, state_d;
    logic        periodic_q, periodic_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] compare_q, compare_d;
    logic [15:0] count_q, count_d;
    logic [15:0] pre_q, pre_d;
    logic        done_q, done_d;
    logic        irq_q, irq_d;
`ifdef TIMER_MATCH_COUNT_EN
    logic [7:0]  mcnt_q, mcnt_d;
`endif

    logic        wr_en;
    logic        ctrl_wr, prescale_wr, compare_wr, count_wr, status_wr;
    logic        stop_req;
    logic        done_set;
    logic        done_clr;
    logic        running;
    logic [7:0]  status_hi;
    logic [15:0] rdata;

    assign running = (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        compare_d  = compare_q;
        count_d    = count_q;
        pre_d      = pre_q;
        done_set   = 1'b0;

        wr_en       = bus.cs & bus.wr;
        ctrl_wr     = wr_en && (bus.addr == 4'h0);
        prescale_wr = wr_en && (bus.addr == 4'h2);
        compare_wr  = wr_en && (bus.addr == 4'h4);
        count_wr    = wr_en && (bus.addr == 4'h6);
        status_wr   = wr_en && (bus.addr == 4'h8);
        // A stop request freezes COUNT and the prescaler on its own edge.
        stop_req    = ctrl_wr && !bus.d_in[0];

        if (running && !stop_req) begin
            if (pre_q == prescale_q) begin
                pre_d = 16'h0000;
                if (count_q == compare_q) begin
                    done_set = 1'b1;
                    if (periodic_q) begin
                        count_d = 16'h0000;
                    end else begin
                        // One-shot: COUNT is left holding the compare value.
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + 16'd1;
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end

        if (ctrl_wr) begin
            periodic_d = bus.d_in[1];
            irq_en_d   = bus.d_in[2];
            if (bus.d_in[0] && !running) begin
                state_d = ST_RUN;
                count_d = 16'h0000;
                pre_d   = 16'h0000;
            end else if (!bus.d_in[0]) begin
                state_d = ST_IDLE;
            end
        end

        if (prescale_wr) begin
            prescale_d = bus.d_in;
        end
        if (compare_wr) begin
            compare_d = bus.d_in;
        end
        // Software load wins over a tick on the same edge.
        if (count_wr) begin
            count_d = bus.d_in;
            pre_d   = 16'h0000;
        end

        // Hardware set has priority over a software clear.
        done_clr = status_wr && bus.d_in[0];
        if (done_set) begin
            done_d = 1'b1;
        end else if (done_clr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        irq_d = done_q & irq_en_q;
    end

`ifdef TIMER_MATCH_COUNT_EN
    always_comb begin
        mcnt_d = mcnt_q;
        if (done_clr) begin
            mcnt_d = 8'h00;
        end
        // Applied after the clear so a match on the clear edge leaves 1.
        if (done_set && (mcnt_d != 8'hFF)) begin
            mcnt_d = mcnt_d + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcnt_q <= 8'h00;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign status_hi = mcnt_q;
`else
    assign status_hi = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= PRESCALE_RST;
            compare_q  <= COMPARE_RST;
            count_q    <= 16'h0000;
            pre_q      <= 16'h0000;
            done_q     <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            compare_q  <= compare_d;
            count_q    <= count_d;
            pre_q      <= pre_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        rdata = 16'h0000;
        case (bus.addr)
            4'h0:    rdata = {13'h0000, irq_en_q, periodic_q, running};
            4'h2:    rdata = prescale_q;
            4'h4:    rdata = compare_q;
            4'h6:    rdata = count_q;
            4'h8:    rdata = {status_hi, 6'b000000, running, done_q};
            default: rdata = 16'h0000;
        endcase
    end

    assign bus.d_out = (bus.cs && bus.rd) ? rdata : 16'h0000;
    assign irq       = irq_q;

endmodule

// File: tb/tb_peripheral_timer.sv
`timescale 1ns/1ps
module tb_peripheral_timer;

    localparam logic [3:0] A_CTRL = 4'h0;
    localparam logic [3:0] A_PRE  = 4'h2;
    localparam logic [3:0] A_CMP  = 4'h4;
    localparam logic [3:0] A_CNT  = 4'h6;
    localparam logic [3:0] A_STAT = 4'h8;

`ifdef TIMER_MATCH_COUNT_EN
    localparam bit MC_EN = 1'b1;
`else
    localparam bit MC_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic irq;
    int   tests_run;
    int   tests_failed;

    peripheral_timer_if bus ();

    peripheral_timer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    // Expected STATUS word built from the bench's own view of the timer.
    function automatic logic [15:0] st(input logic [7:0] mc, input logic run, input logic done);
        return {(MC_EN ? mc : 8'h00), 6'b000000, run, done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [3:0] a, output logic [15:0] v);
        bus.cs   = 1'b1;
        bus.rd   = 1'b1;
        bus.addr = a;
        #1;
        v = bus.d_out;
        bus.cs = 1'b0;
        bus.rd = 1'b0;
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        logic [15:0] v;
        rd_reg(a, v);
        chk(tag, v, exp);
    endtask

    // Write lands on the next rising edge.
    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.cs   = 1'b1;
        bus.wr   = 1'b1;
        bus.addr = a;
        bus.d_in = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.wr = 1'b0;
        $display("[TB] write addr=%h data=%h", a, d);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        chk_reg({pfx, "_ctrl"},   A_CTRL, 16'h0000);
        chk_reg({pfx, "_count"},  A_CNT,  16'h0000);
        chk_reg({pfx, "_status"}, A_STAT, 16'h0000);
        chk_reg({pfx, "_pre"},    A_PRE,  16'h0000);
        chk_reg({pfx, "_cmp"},    A_CMP,  16'hFFFF);
        chk_reg({pfx, "_unmap"},  4'hA,   16'h0000);
        chk({pfx, "_irq"}, {15'h0, irq}, 16'h0000);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        bus.cs   = 1'b0;
        bus.rd   = 1'b0;
        bus.wr   = 1'b0;
        bus.addr = 4'h0;
        bus.d_in = 16'h0000;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset values
        check_reset("rst");
        bus.addr = A_CMP;
        #1;
        chk("dout_no_rd", bus.d_out, 16'h0000);

        // One-shot: PRESCALE=0, COMPARE=3, start at E0
        bus_write(A_PRE, 16'h0000);
        bus_write(A_CMP, 16'h0003);
        bus_write(A_CTRL, 16'h0001);
        chk_reg("os_e0_count", A_CNT, 16'h0000);
        step(1); chk_reg("os_e1_count", A_CNT, 16'h0001);
        step(1); chk_reg("os_e2_count", A_CNT, 16'h0002);
        step(1); chk_reg("os_e3_count", A_CNT, 16'h0003);
        chk_reg("os_e3_status", A_STAT, st(8'd0, 1'b1, 1'b0));
        step(1);
        chk_reg("os_e4_status", A_STAT, st(8'd1, 1'b0, 1'b1));
        chk_reg("os_e4_ctrl",   A_CTRL, 16'h0000);
        chk_reg("os_e4_count",  A_CNT,  16'h0003);
        step(2);
        chk_reg("os_hold_count", A_CNT, 16'h0003);
        bus_write(A_STAT, 16'h0001);
        chk_reg("os_clr_status", A_STAT, st(8'd0, 1'b0, 1'b0));

        // Periodic with irq: PRESCALE=1, COMPARE=1, CTRL=7 at E0
        bus_write(A_PRE, 16'h0001);
        bus_write(A_CMP, 16'h0001);
        bus_write(A_CTRL, 16'h0007);
        chk_reg("per_ctrl", A_CTRL, 16'h0007);
        step(3);
        chk_reg("per_e3_status", A_STAT, st(8'd0, 1'b1, 1'b0));
        chk_reg("per_e3_count",  A_CNT,  16'h0001);
        step(1);
        chk_reg("per_e4_status", A_STAT, st(8'd1, 1'b1, 1'b1));
        chk_reg("per_e4_count",  A_CNT,  16'h0000);
        chk("per_e4_irq", {15'h0, irq}, 16'h0000);
        step(1);
        chk("per_e5_irq", {15'h0, irq}, 16'h0001);
        step(3);
        chk_reg("per_e8_status", A_STAT, st(8'd2, 1'b1, 1'b1));
        chk("per_e8_irq", {15'h0, irq}, 16'h0001);
        step(3);
        // Clear lands on E12, a match edge
        bus_write(A_STAT, 16'h0001);
        chk_reg("sbc_status", A_STAT, st(8'd1, 1'b1, 1'b1));
        bus_write(A_STAT, 16'h0001);
        chk_reg("clr_e13_status", A_STAT, st(8'd0, 1'b1, 1'b0));
        chk("clr_e13_irq", {15'h0, irq}, 16'h0001);
        step(1);
        chk("clr_e14_irq", {15'h0, irq}, 16'h0000);
        chk_reg("clr_e14_count", A_CNT, 16'h0001);
        step(2);
        chk_reg("per_e16_status", A_STAT, st(8'd1, 1'b1, 1'b1));
        step(1);
        // Stop lands on E18, a tick edge that would otherwise bump COUNT
        bus_write(A_CTRL, 16'h0000);
        chk_reg("stop_count",  A_CNT,  16'h0000);
        chk_reg("stop_status", A_STAT, st(8'd1, 1'b0, 1'b1));
        chk_reg("stop_ctrl",   A_CTRL, 16'h0000);
        step(3);
        chk_reg("stop_hold_count",  A_CNT,  16'h0000);
        chk_reg("stop_hold_status", A_STAT, st(8'd1, 1'b0, 1'b1));
        chk("stop_irq", {15'h0, irq}, 16'h0000);

        // Mid-run reset
        bus_write(A_CTRL, 16'h0007);
        step(5);
        chk_reg("mr_pre_status", A_STAT, st(8'd2, 1'b1, 1'b1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset("mrst");

        // Wrap-around: COMPARE=5, one-shot, COUNT loaded to 0x0010
        bus_write(A_CMP, 16'h0005);
        bus_write(A_CTRL, 16'h0001);
        bus_write(A_CNT, 16'h0010);
        chk_reg("wr_load", A_CNT, 16'h0010);
        step(65519);
        chk_reg("wr_ffff",        A_CNT,  16'hFFFF);
        chk_reg("wr_ffff_status", A_STAT, st(8'd0, 1'b1, 1'b0));
        step(1);
        chk_reg("wr_zero", A_CNT, 16'h0000);
        step(5);
        chk_reg("wr_five",        A_CNT,  16'h0005);
        chk_reg("wr_five_status", A_STAT, st(8'd0, 1'b1, 1'b0));
        step(1);
        chk_reg("wr_match_status", A_STAT, st(8'd1, 1'b0, 1'b1));
        chk_reg("wr_match_count",  A_CNT,  16'h0005);
        chk_reg("wr_match_ctrl",   A_CTRL, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
